regfile_mp: RTL and testbench

Parametrised multi-port register file, successor to the single-write/dual-read processor register file. It adds configurable width, depth, read and write port counts, an optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. It also adds a background sequential scrub that zeroes every entry without a full reset. It sits in the decode stage of the MIPS datapath and feeds the operand muxes.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scrub_fsm.sv | 45 ++++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared scrub state type and packed-port slicing helpers for the register file.
package regfile_pkg;

    typedef enum logic {IDLE, SCRUB} scrub_state_t;

    function automatic int portLo(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/regfile_scrub_fsm.sv
// regfile_scrub_fsm: sequential zeroing walk over every entry, one entry per cycle.
module regfile_scrub_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_start,
    output logic              scrubWe,
    output logic [ADDR_W-1:0] scrubAddr,
    output logic              scrub_busy,
    output logic              scrub_done
);

    scrub_state_t state, stateNext;
    logic [ADDR_W-1:0] ptr, ptrNext;
    logic doneNext, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            scrub_done <= 1'b0;
        end else begin
            state      <= stateNext;
            ptr        <= ptrNext;
            scrub_done <= doneNext;
        end
    end

    // ptr only ever leaves 0 while walking, so it returns to 0 on the way back to IDLE
    always_comb begin
        last      = ptr == ADDR_W'(NUM_REGS - 1);
        stateNext = (state == IDLE) ? (scrub_start ? SCRUB : IDLE) : (last ? IDLE : SCRUB);
        ptrNext   = (state == SCRUB && !last) ? ptr + 1'b1 : '0;
        doneNext  = state == SCRUB && last;
    end

    assign scrub_busy = state == SCRUB;
    assign scrubWe    = scrub_busy;
    assign scrubAddr  = ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional zero register, write bypass
// and a background scrub that zeroes all entries.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     scrub_start,
    output logic                     scrub_busy,
    output logic                     scrub_done
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [NUM_WR-1:0] wen;
    logic              scrubWe;
    logic [ADDR_W-1:0] scrubAddr;

    regfile_scrub_fsm #(.NUM_REGS(NUM_REGS)) u_scrub (
        .clk        (clk),
        .rst        (rst),
        .scrub_start(scrub_start),
        .scrubWe    (scrubWe),
        .scrubAddr  (scrubAddr),
        .scrub_busy (scrub_busy),
        .scrub_done (scrub_done)
    );

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wen[w] = we[w] && !(ZERO_REG && wr_addr[portLo(w, ADDR_W) +: ADDR_W] == '0);
    end

    // Later assignments win: scrub zero first, then ports in ascending index order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            if (scrubWe) mem[scrubAddr] <= '0;
            for (int p = 0; p < NUM_WR; p++)
                if (wen[p]) mem[wr_addr[portLo(p, ADDR_W) +: ADDR_W]] <= wr_data[portLo(p, DATA_W) +: DATA_W];
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        assign ra = rd_addr[portLo(r, ADDR_W) +: ADDR_W];
        always_comb begin
            val = mem[ra];
            for (int p = 0; p < NUM_WR; p++)
                if (BYPASS && we[p] && wr_addr[portLo(p, ADDR_W) +: ADDR_W] == ra)
                    val = wr_data[portLo(p, DATA_W) +: DATA_W];
            if (ZERO_REG && ra == '0) val = '0;
        end
        assign rd_data[portLo(r, DATA_W) +: DATA_W] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        scrub_start;
    logic        scrub_busy;
    logic        scrub_done;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] act;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .scrub_start(scrub_start),
        .scrub_busy (scrub_busy),
        .scrub_done (scrub_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel 0/1 = read port, 2 = scrub_busy, 3 = scrub_done
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = e.sel == 2 ? 32'(scrub_busy) : e.sel == 3 ? 32'(scrub_done) : rd_data[e.sel*32 +: 32];
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s cyc %0d (due %0d): got %h want %h", e.name, cyc, e.cyc, act, e.exp);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        we = '0;
        scrub_start = 1'b0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        we[p] = 1'b1;
        wr_addr[p*5 +: 5] = 5'(a);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int r, input int a);
        rd_addr[r*5 +: 5] = 5'(a);
    endtask

    task automatic want(input string n, input int sel, input logic [31:0] v);
        q.push_back('{cyc, n, sel, v});
    endtask

    task automatic fillIndex();
        for (int i = 0; i < 32; i += 2) begin
            nextCycle();
            wr(0, i, 32'(i));
            wr(1, i + 1, 32'(i + 1));
        end
    endtask

    initial begin
        rst = 1'b1; we = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; scrub_start = 1'b0;
        repeat (2) @(posedge clk);

        nextCycle();
        rd(0, 3); rd(1, 31);
        want("rst_rd0", 0, 0); want("rst_rd1", 1, 0); want("rst_busy", 2, 0); want("rst_done", 3, 0);

        nextCycle();
        wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 5);
        want("byp_rd0", 0, 32'hDEADBEEF); want("byp_rd1", 1, 32'hDEADBEEF);
        nextCycle();
        rd(0, 4); rd(1, 5);
        want("arr_rd0", 0, 0); want("arr_rd1", 1, 32'hDEADBEEF);

        nextCycle();
        wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
        want("prio_byp", 0, 32'h2222);
        nextCycle();
        rd(0, 7);
        want("prio_arr", 0, 32'h2222); want("prio_keep", 1, 32'hDEADBEEF);

        nextCycle();
        wr(0, 12, 32'h55); wr(1, 13, 32'h66); rd(0, 12); rd(1, 13);
        want("byp_p0", 0, 32'h55); want("byp_p1", 1, 32'h66);

        nextCycle();
        wr(0, 0, 32'hFFFFFFFF); rd(0, 0); rd(1, 0);
        want("zero_same0", 0, 0); want("zero_same1", 1, 0);
        nextCycle();
        want("zero_next0", 0, 0); want("zero_next1", 1, 0);

        fillIndex();
        for (int i = 0; i < 32; i += 2) begin
            nextCycle();
            rd(0, i); rd(1, i + 1);
            want("fill0", 0, 32'(i)); want("fill1", 1, 32'(i + 1));
        end

        nextCycle();
        scrub_start = 1'b1;
        want("scr_busy0", 2, 0); want("scr_done0", 3, 0);
        for (int k = 1; k <= 34; k++) begin
            nextCycle();
            want("scr_busy", 2, 32'(k <= 32)); want("scr_done", 3, 32'(k == 33));
            if (k == 5) scrub_start = 1'b1;
            if (k == 3) begin
                rd(0, 1); rd(1, 20);
                want("scr_rd_cleared", 0, 0); want("scr_rd_pending", 1, 20);
            end
            if (k == 11) begin
                wr(0, 10, 32'hABCD); rd(0, 10);
                want("scr_byp", 0, 32'hABCD);
            end
        end
        for (int i = 0; i < 32; i += 2) begin
            nextCycle();
            rd(0, i); rd(1, i + 1);
            want("post_scr0", 0, i == 10 ? 32'hABCD : 32'h0); want("post_scr1", 1, 0);
        end

        fillIndex();
        nextCycle();
        scrub_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            if (k == 12) begin
                rd(1, 25);
                want("pre_rst", 1, 25); want("pre_rst_busy", 2, 1);
                rst = 1'b1;
            end
        end
        for (int j = 0; j < 28; j++) begin
            nextCycle();
            want("rst_mid_busy", 2, 0); want("rst_mid_done", 3, 0);
            if (j < 16) begin
                rd(0, 2 * j); rd(1, 2 * j + 1);
                want("rst_mid_rd0", 0, 0); want("rst_mid_rd1", 1, 0);
            end
        end

        repeat (2) nextCycle();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
